// File: rtl/uart_tx_serializer.sv
// 8N1-style serializer: one start bit, DATA_BITS payload bits LSB first, one stop bit, CLK_DIV clocks per bit.
// Line goes low one cycle after tx_start is accepted; requests arriving while busy are dropped, not queued.
module uart_tx_serializer #(
   parameter int CLK_DIV   = 5208,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_start,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t               r_state;
   logic [BAUD_W-1:0]    r_baud;
   logic [BIT_W-1:0]     r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_tx;
   logic                 r_busy;
   logic                 r_done;

   state_t               w_state;
   logic [BAUD_W-1:0]    w_baud;
   logic [BIT_W-1:0]     w_bit;
   logic [DATA_BITS-1:0] w_shift;
   logic                 w_tx;
   logic                 w_busy;
   logic                 w_done;
   logic                 w_baud_end;

   assign w_baud_end = (r_baud == BAUD_LAST);

   // Every output is computed one cycle ahead so it can leave straight from a flop.
   always_comb begin
      w_state = r_state;
      w_baud  = r_baud;
      w_bit   = r_bit;
      w_shift = r_shift;
      w_tx    = r_tx;
      w_busy  = r_busy;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx   = 1'b1;
            w_busy = 1'b0;
            if (tx_start) begin
               w_state = S_START;
               w_baud  = '0;
               w_bit   = '0;
               w_shift = tx_data;
               w_tx    = 1'b0;
               w_busy  = 1'b1;
            end
         end
         S_START: begin
            if (w_baud_end) begin
               w_state = S_DATA;
               w_baud  = '0;
               w_tx    = r_shift[0];
            end else begin
               w_baud = r_baud + BAUD_ONE;
            end
         end
         S_DATA: begin
            if (w_baud_end) begin
               w_baud  = '0;
               w_shift = r_shift >> 1;
               w_bit   = r_bit + BIT_ONE;
               if (r_bit == BIT_LAST) begin
                  w_state = S_STOP;
                  w_tx    = 1'b1;
               end else begin
                  w_tx = r_shift[1];
               end
            end else begin
               w_baud = r_baud + BAUD_ONE;
            end
         end
         S_STOP: begin
            w_tx = 1'b1;
            if (w_baud_end) begin
               w_state = S_IDLE;
               w_baud  = '0;
               w_busy  = 1'b0;
               w_done  = 1'b1;
            end else begin
               w_baud = r_baud + BAUD_ONE;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_tx    = 1'b1;
            w_busy  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_baud  <= w_baud;
         r_bit   <= w_bit;
         r_shift <= w_shift;
         r_tx    <= w_tx;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign tx      = r_tx;
   assign busy    = r_busy;
   assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: three instances (4/8, 2/5, 65535/8) checked every cycle against a frame-timing model.
module tb_uart_tx_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0] rst_v   = 3'b111;
   logic [2:0] start_v = 3'b000;
   logic [7:0] data_v [3];
   logic tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
   logic [2:0] tx_v, busy_v, done_v;
   assign tx_v   = {tx2, tx1, tx0};
   assign busy_v = {busy2, busy1, busy0};
   assign done_v = {done2, done1, done0};

   uart_tx_serializer #(.CLK_DIV(4), .DATA_BITS(8)) u_a (
      .clk(clk), .rst(rst_v[0]), .tx_start(start_v[0]), .tx_data(data_v[0]),
      .tx(tx0), .busy(busy0), .tx_done(done0));
   uart_tx_serializer #(.CLK_DIV(2), .DATA_BITS(5)) u_b (
      .clk(clk), .rst(rst_v[1]), .tx_start(start_v[1]), .tx_data(data_v[1][4:0]),
      .tx(tx1), .busy(busy1), .tx_done(done1));
   uart_tx_serializer #(.CLK_DIV(65535), .DATA_BITS(8)) u_c (
      .clk(clk), .rst(rst_v[2]), .tx_start(start_v[2]), .tx_data(data_v[2]),
      .tx(tx2), .busy(busy2), .tx_done(done2));

   int total = 0;
   int bad   = 0;
   bit cmp_on = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a frame is just a cycle index t; the symbol on the line is t / CLK_DIV.
   int         cdiv  [3] = '{4, 2, 65535};
   int         dbits [3] = '{8, 5, 8};
   int         m_t   [3] = '{0, 0, 0};
   bit         m_act [3] = '{0, 0, 0};
   bit         m_done[3] = '{0, 0, 0};
   logic [7:0] m_data[3];

   function automatic int exp_line(input int i);
      int sym;
      if (!m_act[i]) return 1;
      sym = m_t[i] / cdiv[i];
      if (sym == 0) return 0;
      if (sym <= dbits[i]) return int'(m_data[i][sym-1]);
      return 1;
   endfunction

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (rst_v[i]) begin
            m_act[i]  = 1'b0;
            m_done[i] = 1'b0;
         end else begin
            m_done[i] = 1'b0;
            if (m_act[i]) begin
               m_t[i]++;
               if (m_t[i] == (dbits[i] + 2) * cdiv[i]) begin
                  m_act[i]  = 1'b0;
                  m_done[i] = 1'b1;
               end
            end else if (start_v[i]) begin
               m_act[i]  = 1'b1;
               m_t[i]    = 0;
               m_data[i] = data_v[i];
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_on) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("line_u%0d", i), int'(tx_v[i]), exp_line(i));
            check($sformatf("busy_u%0d", i), int'(busy_v[i]), int'(m_act[i]));
            check($sformatf("done_u%0d", i), int'(done_v[i]), int'(m_done[i]));
         end
      end
   end

   // Recorded outputs, index n = cycles after the edge that accepted tx_start.
   bit rec_tx  [70000];
   bit rec_busy[70000];
   bit rec_done[70000];

   task automatic run(input int i, input logic [7:0] d, input int len,
                      input int inj_n, input logic [7:0] inj_d, input int rst_n);
      data_v[i]  = d;
      start_v[i] = 1'b1;
      @(posedge clk);
      #1 start_v[i] = 1'b0;
      for (int n = 0; n < len; n++) begin
         @(negedge clk);
         rec_tx[n]   = tx_v[i];
         rec_busy[n] = busy_v[i];
         rec_done[n] = done_v[i];
         #1;
         start_v[i] = 1'b0;
         rst_v[i]   = 1'b0;
         if (n == inj_n) begin
            data_v[i]  = inj_d;
            start_v[i] = 1'b1;
         end
         if (n == rst_n) rst_v[i] = 1'b1;
      end
   endtask

   // exp bit j is the j-th symbol on the line (start bit first).
   task automatic check_bits(input string name, input int base, input int c,
                             input int nsym, input logic [15:0] exp);
      for (int j = 0; j < nsym; j++)
         check($sformatf("%s_sym%0d", name, j), int'(rec_tx[base + j*c + c/2]), int'(exp[j]));
   endtask

   function automatic int count_busy(input int len);
      int s = 0;
      for (int n = 0; n < len; n++) s += int'(rec_busy[n]);
      return s;
   endfunction

   function automatic int count_done(input int len);
      int s = 0;
      for (int n = 0; n < len; n++) s += int'(rec_done[n]);
      return s;
   endfunction

   function automatic int first_done(input int len);
      for (int n = 0; n < len; n++) if (rec_done[n]) return n;
      return -1;
   endfunction

   initial begin
      data_v[0] = 8'h00; data_v[1] = 8'h00; data_v[2] = 8'h00;

      // Reset held three cycles on all instances
      @(negedge clk);
      cmp_on = 1'b1;
      check("rst_tx", int'(tx0), 1);
      check("rst_busy", int'(busy0), 0);
      check("rst_done", int'(done0), 0);
      repeat (2) @(negedge clk);
      #1 rst_v = 3'b000;
      repeat (2) @(negedge clk);
      check("post_rst_tx", int'(tx0), 1);
      check("post_rst_busy", int'(busy0), 0);
      #1;

      // Single frame 0xA5
      run(0, 8'hA5, 45, -1, 8'h00, -1);
      check("a5_first_low", int'(rec_tx[0]), 0);
      check_bits("a5", 0, 4, 10, 16'b11_0100_1010);
      check("a5_busy_cycles", count_busy(45), 40);
      check("a5_done_count", count_done(45), 1);
      check("a5_done_at", first_done(45), 40);
      check("a5_idle_after", int'(rec_tx[44]), 1);

      // 0x3C with a 0xFF request 12 cycles in: must be ignored
      run(0, 8'h3C, 50, 12, 8'hFF, -1);
      check_bits("3c", 0, 4, 10, 16'b10_0111_1000);
      check("3c_busy_cycles", count_busy(50), 40);
      check("3c_done_count", count_done(50), 1);

      // Back-to-back: 0x00 then 0xFF requested in the tx_done cycle
      run(0, 8'h00, 90, 40, 8'hFF, -1);
      check_bits("b2b0", 0, 4, 10, 16'b10_0000_0000);
      check("b2b_done_cycle_line", int'(rec_tx[40]), 1);
      check("b2b_second_start", int'(rec_tx[41]), 0);
      check_bits("b2bff", 41, 4, 10, 16'b11_1111_1110);
      check("b2b_done_count", count_done(90), 2);
      check("b2b_first_done", first_done(90), 40);
      check("b2b_second_done", int'(rec_done[81]), 1);
      check("b2b_busy_cycles", count_busy(90), 80);

      // 0x55 aborted by reset during data bit 3, then a clean 0x81 frame
      run(0, 8'h55, 30, -1, 8'h00, 17);
      check("abort_mid_bit3", int'(rec_tx[17]), 0);
      check("abort_busy_before", int'(rec_busy[17]), 1);
      check("abort_tx", int'(rec_tx[18]), 1);
      check("abort_busy", int'(rec_busy[18]), 0);
      check("abort_no_done", count_done(30), 0);
      run(0, 8'h81, 45, -1, 8'h00, -1);
      check_bits("81", 0, 4, 10, 16'b11_0000_0010);
      check("81_done_at", first_done(45), 40);

      // CLK_DIV=2, DATA_BITS=5, payload 0x15
      run(1, 8'h15, 20, -1, 8'h00, -1);
      check_bits("b15", 0, 2, 7, 16'b110_1010);
      check("b15_busy_cycles", count_busy(20), 14);
      check("b15_done_at", first_done(20), 14);

      // CLK_DIV=65535: start bit length only, then abandon via reset
      run(2, 8'h01, 65540, -1, 8'h00, -1);
      begin
         int zeros = 0;
         while (zeros < 65540 && rec_tx[zeros] == 1'b0) zeros++;
         check("wide_start_len", zeros, 65535);
      end
      check("wide_bit0", int'(rec_tx[65535]), 1);
      check("wide_busy", int'(rec_busy[65535]), 1);
      rst_v[2] = 1'b1;
      @(negedge clk);
      check("wide_abort_busy", int'(busy2), 0);
      check("wide_abort_tx", int'(tx2), 1);
      #1 rst_v[2] = 1'b0;
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parallel-to-serial transmitter that converts a byte held in the design's D-register stage into an asynchronous serial frame on a single output line: 8N1 format, LSB first. It is the sending end of the serial link whose receive side samples into flip-flop registers. It sits between the control FSM, which presents a byte plus a start strobe, and the board TX pin. It reports busy/done through a simple strobe handshake.

## Interface

Parameters:
- CLK_DIV, 5208: clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
- DATA_BITS, 8: payload bits per frame; legal range 5..8.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  synchronous, active-high reset.
- tx_start  input  1  single-cycle request to send tx_data; honoured only when busy=0.
- tx_data  input  DATA_BITS  payload; sampled on the edge that accepts tx_start.
- tx  output  1  registered serial line; idle-high.
- busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-cycle pulse when the stop bit completes.

## Operation

- Reset values: tx=1, busy=0, tx_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- The FSM has four states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If tx_start=1, load the shift register with tx_data, clear both counters, and go to START.
- START:
  - tx=0 for CLK_DIV cycles, then go to DATA.
- DATA:
  - tx = shift register bit 0.
  - After each CLK_DIV cycles, shift right and increment the bit counter.
  - After DATA_BITS bits, go to STOP.
- STOP:
  - tx=1 for CLK_DIV cycles.
  - Then go to IDLE, pulse tx_done for one cycle, and drop busy.
- Baud counter: counts 0..CLK_DIV-1 and wraps to 0 on each bit boundary. Width is clog2(CLK_DIV); it must not overflow at CLK_DIV=65535.
- Bit counter: width clog2(DATA_BITS+1); no wrap within a frame.
- tx_start while busy=1 is ignored with no queuing; tx_data changes while busy have no effect on the frame.
- tx_start in the cycle tx_done=1 is accepted, because the FSM is already in IDLE. This allows back-to-back frames with no idle gap beyond that one cycle.
- Reset mid-frame: on the next edge all outputs return to reset values, and the partial frame is abandoned with tx forced to 1. No tx_done is generated for the aborted frame.
- rst has priority over tx_start in the same cycle.

## Timing

- tx_start sampled high at edge k:
  - tx=0 and busy=1 from edge k+1.
  - Start bit occupies edges k+1 .. k+CLK_DIV.
  - Data bit i occupies edges k+1+(i+1)·CLK_DIV .. k+(i+2)·CLK_DIV.
  - Stop bit follows the last data bit.
- Frame length is (DATA_BITS+2)·CLK_DIV cycles.
- busy falls and tx_done rises on edge k+1+(DATA_BITS+2)·CLK_DIV; tx_done is high for exactly one cycle.
- Output latency from tx_start to the first line transition is 1 cycle.
- All outputs are registered, with no combinational path from input to output.
- Minimum period between accepted tx_start pulses is (DATA_BITS+2)·CLK_DIV+1 cycles.

## Test plan

1. Reset, CLK_DIV=4, DATA_BITS=8: hold rst 3 cycles → tx=1, busy=0, tx_done=0 throughout and after release with tx_start=0.
2. Single frame, CLK_DIV=4: tx_start pulse with tx_data=0xA5 at edge k.
   - Line sequence (each level held 4 cycles): 0, then 1,0,1,0,0,1,0,1, then 1.
   - busy high for 40 cycles; tx_done pulses once at k+41.
3. Ignore while busy, CLK_DIV=4: send 0x3C, then pulse tx_start with tx_data=0xFF at cycle 12 of the frame → serialized bits remain 0x3C, exactly one tx_done, no second frame follows.
4. Back-to-back, CLK_DIV=4: send 0x00, then assert tx_start with 0xFF in the tx_done cycle.
   - Second start bit begins on the next edge.
   - Line shows stop(1) for 4 cycles then start(0); both frames decode correctly.
5. Reset mid-frame, CLK_DIV=4: start 0x55 and assert rst during data bit 3.
   - Next edge: tx=1, busy=0; no tx_done.
   - A fresh tx_start with 0x81 then produces a clean full frame.
6. Extreme parameters: CLK_DIV=2 with DATA_BITS=5 sends 0x15 → 14-cycle frame, bits 1,0,1,0,1. CLK_DIV=65535 sends one bit → start bit lasts exactly 65535 cycles, with no counter overflow.
